// File: rtl/result_dump_uart_if.sv
// Data-RAM read port shared between the processor and the result dumper.
// The dumper drives the address side (master); the RAM returns read data (slave).
interface result_dump_uart_if;
    logic        MemSel;
    logic [31:0] MemAddr;
    logic [31:0] ReadData;

    modport master (
        output MemSel,
        output MemAddr,
        input  ReadData
    );

    modport slave (
        input  MemSel,
        input  MemAddr,
        output ReadData
    );
endinterface

// File: rtl/result_dump_uart.sv
// Result dumper: on a rising EndFlag, reads DUMP_WORDS words from the data RAM
// starting at DUMP_BASE and ships each one over an 8N1 UART, MSB byte first,
// bits within a byte LSB first. Busy covers the whole dump; Done holds until
// EndFlag is released.
module result_dump_uart #(
    parameter logic [31:0] DUMP_BASE    = 32'd1024,
    parameter int          DUMP_WORDS   = 256,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      EndFlag,
    result_dump_uart_if.master        mem,
    output logic                      tx,
    output logic                      Busy,
    output logic                      Done
);

    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int WIDX_W = $clog2(DUMP_WORDS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(DUMP_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LATCH,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t              state_q,    state_d;
    logic                end_flag_q;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q,  bit_idx_d;
    logic [CNT_W-1:0]    clk_cnt_q,  clk_cnt_d;
    logic [31:0]         shreg_q,    shreg_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic                tx_q,       tx_d;

    logic                trigger;
    logic                bit_done;
    logic [7:0]          tx_byte;

    // A dump starts only on a genuine low-to-high EndFlag transition.
    assign trigger  = EndFlag & ~end_flag_q;
    assign bit_done = (clk_cnt_q == CNT_LAST);

    // Next-state and datapath updates; tx is computed from the *next* state so the
    // registered line lines up exactly with the state that owns it.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        clk_cnt_d  = clk_cnt_q;
        shreg_d    = shreg_q;
        mem_addr_d = mem_addr_q;
        tx_d       = 1'b1;
        tx_byte    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d    = S_ADDR;
                    word_idx_d = '0;
                end
            end
            S_ADDR: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shreg_d    = mem.ReadData;
                byte_idx_d = 2'd0;
                clk_cnt_d  = '0;
                state_d    = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q != 2'd3) begin
                        shreg_d    = {shreg_q[23:0], 8'h00};
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_START;
                    end else if (word_idx_q < WIDX_LAST) begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!EndFlag) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address is loaded as ADDR is entered so it is stable for the whole ADDR cycle
        // and held afterwards; the add wraps modulo 2^32.
        if (state_d == S_ADDR) begin
            mem_addr_d = DUMP_BASE + (32'(word_idx_d) << 2);
        end

        tx_byte = shreg_d[31:24];
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; EndFlag history resets high so a level held
    // through reset never looks like a fresh edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            end_flag_q <= 1'b1;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            bit_idx_q  <= 3'd0;
            clk_cnt_q  <= '0;
            shreg_q    <= 32'h0;
            mem_addr_q <= DUMP_BASE;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            end_flag_q <= EndFlag;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            clk_cnt_q  <= clk_cnt_d;
            shreg_q    <= shreg_d;
            mem_addr_q <= mem_addr_d;
            tx_q       <= tx_d;
        end
    end

    assign Busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done        = (state_q == S_DONE);
    assign mem.MemSel  = Busy;
    assign mem.MemAddr = mem_addr_q;
    assign tx          = tx_q;

endmodule

// File: tb/tb_result_dump_uart.sv
// Bench for result_dump_uart: a registered-read RAM model, a scoreboard of expected
// UART bytes and RAM addresses filled when a dump is requested, and an independent
// per-cycle monitor holding a UART decoder that pops and compares.
module tb_result_dump_uart;

    localparam int          CPB      = 4;
    localparam int          DW       = 2;
    localparam logic [31:0] BASE     = 32'd1024;
    localparam int          BUSY_LEN = DW * (3 + 40 * CPB);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic EndFlag = 1'b0;
    logic tx, Busy, Done;

    result_dump_uart_if ram_bus ();

    result_dump_uart #(
        .DUMP_BASE   (BASE),
        .DUMP_WORDS  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .EndFlag(EndFlag),
        .mem    (ram_bus),
        .tx     (tx),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // RAM model: one-cycle registered read.
    logic [31:0] ram [0:DW-1];
    logic [31:0] rd_q;

    function automatic logic [31:0] ram_lookup(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (a >= BASE && off[1:0] == 2'b00 && (off >> 2) < DW)
            return ram[off >> 2];
        return 32'hA5A5_0000 ^ a;
    endfunction

    always @(posedge clk) rd_q <= ram_lookup(ram_bus.MemAddr);
    assign ram_bus.ReadData = rd_q;

    // Scoreboard queues.
    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_addrs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- monitor: decoder + per-cycle checks ----------------
    bit          rx_active = 0;
    int          rx_cnt    = 0;
    logic [7:0]  rx_byte   = 8'h00;
    int          busy_cnt  = 0;
    logic        memsel_prev = 1'b0;
    logic [31:0] addr_prev   = 32'h0;

    always @(negedge clk) begin
        if (!reset) begin
            rx_active   = 0;
            rx_cnt      = 0;
            busy_cnt    = 0;
            memsel_prev = 1'b0;
        end else begin
            chk("memsel_eq_busy", 32'(ram_bus.MemSel), 32'(Busy));
            chk("done_while_busy", 32'(Busy & Done), 32'd0);
            if (!Busy) chk("tx_idle_high", 32'(tx), 32'd1);

            // Address scoreboard: each new address presented while selected.
            if (ram_bus.MemSel && (!memsel_prev || ram_bus.MemAddr != addr_prev)) begin
                if (exp_addrs.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_addr: got %0d expected none", ram_bus.MemAddr);
                end else begin
                    chk("mem_addr", ram_bus.MemAddr, exp_addrs.pop_front());
                end
            end
            memsel_prev = ram_bus.MemSel;
            addr_prev   = ram_bus.MemAddr;

            // Busy length and Done-after-Busy.
            if (Busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                chk("busy_len", 32'(busy_cnt), 32'(BUSY_LEN));
                chk("done_after_busy", 32'(Done), 32'd1);
                busy_cnt = 0;
            end

            // UART decoder, mid-bit sampling.
            if (!rx_active) begin
                if (tx == 1'b0) begin
                    rx_active = 1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    int slot;
                    slot = rx_cnt / CPB;
                    if (slot == 0) begin
                        chk("start_bit", 32'(tx), 32'd0);
                    end else if (slot <= 8) begin
                        rx_byte[slot-1] = tx;
                    end else begin
                        chk("stop_bit", 32'(tx), 32'd1);
                        if (exp_bytes.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_byte: got %02h expected none", rx_byte);
                        end else begin
                            chk("uart_byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
                        end
                        rx_active = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Reference: a dump sends words BASE..BASE+4*(DW-1), each MSB byte first.
    task automatic issue_dump();
        for (int w = 0; w < DW; w++) begin
            exp_addrs.push_back(BASE + 32'(4 * w));
            for (int b = 0; b < 4; b++)
                exp_bytes.push_back(8'(ram[w] >> (24 - 8 * b)));
        end
        @(negedge clk);
        EndFlag = 1'b1;
        $display("dump requested: words %08h %08h", ram[0], ram[1]);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (Busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(Busy), 32'(lvl));
    endtask

    task automatic check_drained(input string name);
        repeat (4) @(negedge clk);
        chk({name, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
        chk({name, "_addrs_left"}, 32'(exp_addrs.size()), 32'd0);
        exp_bytes.delete();
        exp_addrs.delete();
    endtask

    task automatic randomize_ram();
        for (int w = 0; w < DW; w++) ram[w] = $urandom;
    endtask

    initial begin
        ram[0] = 32'h1234_5678;
        ram[1] = 32'hDEAD_BEEF;

        // T1: held in reset while EndFlag toggles.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            EndFlag = ~EndFlag;
            #1;
            chk("reset_outputs", {28'h0, tx, ram_bus.MemSel, Busy, Done}, 32'b1000);
        end
        chk("reset_memaddr", ram_bus.MemAddr, BASE);

        // Level high out of reset must not trigger.
        @(negedge clk);
        EndFlag = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_trigger_from_level", 32'(Busy), 32'd0);
        end
        EndFlag = 1'b0;

        // T2/T3: basic dump with fixed words.
        issue_dump();
        wait_busy(1'b1, 5, "busy_rise");
        wait_busy(1'b0, BUSY_LEN + 10, "busy_fall");
        check_drained("basic");

        // T4: EndFlag still high -> no second dump, Done held.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("no_retrigger_busy", 32'(Busy), 32'd0);
        end
        chk("done_held", 32'(Done), 32'd1);
        EndFlag = 1'b0;
        @(negedge clk);
        chk("done_cleared", 32'(Done), 32'd0);
        issue_dump();
        wait_busy(1'b1, 5, "busy_rise2");
        wait_busy(1'b0, BUSY_LEN + 10, "busy_fall2");
        check_drained("second");

        // T5: reset in the middle of the second byte's data bits.
        EndFlag = 1'b0;
        @(negedge clk);
        ram[0] = 32'h1234_5678;
        ram[1] = $urandom;
        issue_dump();
        wait_busy(1'b1, 5, "busy_rise3");
        repeat (55) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_tx_high", 32'(tx), 32'd1);
        chk("abort_busy_low", 32'(Busy), 32'd0);
        chk("abort_memsel_low", 32'(ram_bus.MemSel), 32'd0);
        exp_bytes.delete();
        exp_addrs.delete();
        EndFlag = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue_dump();
        wait_busy(1'b1, 5, "busy_rise_restart");
        wait_busy(1'b0, BUSY_LEN + 10, "busy_fall_restart");
        check_drained("restart");

        // T6: EndFlag dropped part-way through word 0, random data.
        for (int n = 0; n < 4; n++) begin
            EndFlag = 1'b0;
            @(negedge clk);
            randomize_ram();
            issue_dump();
            wait_busy(1'b1, 5, "busy_rise_drop");
            repeat ($urandom_range(1, 150)) @(negedge clk);
            EndFlag = 1'b0;
            wait_busy(1'b0, BUSY_LEN + 10, "busy_fall_drop");
            @(negedge clk);
            chk("done_pulse_one_cycle", 32'(Done), 32'd0);
            check_drained("drop");
        end

        repeat (20) @(negedge clk);
        chk("final_bytes_left", 32'(exp_bytes.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
